regfile_dump_reader: RTL
========================

Name: regfile_dump_reader

Overview:
- Sequential reader that walks the register file's read port from address 0 to NUM_REGS-1 and streams each (index, value) pair out over a valid/ready interface.
- Consumed by the debug/trace path for end-of-run and on-demand register dumps.
- Complements the register file's write path: the register file is written by writeback; this block is the read-side consumer.
- Drives one register-file read address and samples the combinational read data.

Parameters:
- NUM_REGS, 32, number of registers walked (indices 0..NUM_REGS-1).
- ADDR_W, 5, register index width; must satisfy 2^ADDR_W >= NUM_REGS.
- DATA_W, 32, register data width.
- SKIP_ZERO, 0, when 1, registers reading exactly 0 are not emitted.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset_L  in  1  asynchronous active-low reset.
- start  in  1  single-cycle dump request; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last register has been handled.
- rdAddr  out  ADDR_W  read address to the register file read port.
- rdData  in  DATA_W  combinational read data for rdAddr.
- outValid  out  1  outIndex and outData hold a valid beat.
- outReady  in  1  consumer accepts the beat when outValid is also high.
- outIndex  out  ADDR_W  register index of the current beat.
- outData  out  DATA_W  register value of the current beat.

Behaviour:
- Reset (Reset_L low, asynchronous): state=IDLE; rdAddr=0, outIndex=0, outData=0, outValid=0, busy=0, done=0.
- IDLE:
  - start=1 -> rdAddr=0, go to READ.
  - Otherwise stay in IDLE.
- READ (rdAddr is stable for the whole cycle):
  - On the rising edge, capture rdData into outData and rdAddr into outIndex.
  - If SKIP_ZERO=1 and rdData==0: emit no beat.
    - If rdAddr==NUM_REGS-1, go to DONE.
    - Otherwise rdAddr+1, stay in READ.
  - Otherwise set outValid=1 and go to HOLD.
- HOLD:
  - outValid=1; outIndex and outData are held stable until accepted.
  - Acceptance is outValid&&outReady at a rising edge. On acceptance, outValid=0, then:
    - If outIndex==NUM_REGS-1, go to DONE.
    - Otherwise rdAddr=outIndex+1, go to READ.
  - outReady low: stay in HOLD indefinitely with no change.
- DONE: done=1 for exactly one cycle, then go to IDLE. rdAddr returns to 0.
- start:
  - Ignored in READ, HOLD and DONE; no queuing.
  - A start in the cycle done is high is ignored.
- Latency and throughput:
  - start sampled at edge k -> first outValid high after edge k+1.
  - With outReady held at 1, one beat every 2 cycles.
  - Full dump with SKIP_ZERO=0: last acceptance at edge k+64 (NUM_REGS=32); done high during the cycle after it.
- Coherency:
  - Each value is the read-port value at the rising edge that ends READ for that index.
  - Register-file writes between beats are visible. The dump is not an atomic snapshot.
- Address arithmetic: rdAddr never exceeds NUM_REGS-1 and never wraps.
- Reset mid-dump: everything returns to reset values immediately.
  - outValid drops asynchronously.
  - done does not pulse.
  - The dump does not resume after reset.
- Not supported: outReady high with outValid low (no effect); abort other than reset.

Test Plan:
- Ready always high, SKIP_ZERO=0, reg[i]=i*3:
  - start pulse -> 32 beats, outIndex 0..31, outData 0,3,...,93, in order.
  - Beat i accepted at edge 2i+2 after start is sampled.
  - done pulses exactly once, busy falls the following cycle.
- Backpressure: outReady low for 5 cycles while beat 7 (data 21) is valid.
  - outValid stays 1; outIndex=7 and outData=21 stay stable all 5 cycles.
  - rdAddr does not advance; beat 8 follows acceptance.
- SKIP_ZERO=1, only reg[3]=0xDEADBEEF and reg[31]=5 non-zero:
  - Exactly 2 beats, (3, 0xDEADBEEF) then (31, 5), then done.
  - With all registers zero: no beat and a single done pulse.
- start re-asserted during beat 10 and on the done cycle:
  - Both are ignored; exactly 32 beats total, one done.
  - A later start in IDLE begins a new dump at index 0.
- Reset_L pulsed low during HOLD on beat 12:
  - outValid=0, busy=0, rdAddr=0 asynchronously; no done pulse.
  - After release, the block stays IDLE until the next start.
- A register-file write of reg[20]=77 while the reader holds beat 5 -> beat 20 reports 77.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks a register file read port and streams (index, value) beats over valid/ready
module regfile_dump_reader #(
   parameter int NUM_REGS  = 32,
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 32,
   parameter bit SKIP_ZERO = 1'b0
) (
   input  logic              CLK,
   input  logic              Reset_L,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rdAddr,
   input  logic [DATA_W-1:0] rdData,
   output logic              outValid,
   input  logic              outReady,
   output logic [ADDR_W-1:0] outIndex,
   output logic [DATA_W-1:0] outData
);
   typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
   state_t state;
   logic skipBeat;
   assign skipBeat = SKIP_ZERO && (rdData == '0);
   always_ff @(posedge CLK or negedge Reset_L)
      if (!Reset_L) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         rdAddr   <= '0;
         outValid <= 1'b0;
         outIndex <= '0;
         outData  <= '0;
      end else
         case (state)
            IDLE:
               if (start) begin
                  state  <= READ;
                  busy   <= 1'b1;
                  rdAddr <= '0;
               end
            READ: begin
               outData  <= rdData;
               outIndex <= rdAddr;
               if (!skipBeat) begin
                  outValid <= 1'b1;
                  state    <= HOLD;
               end else if (rdAddr == LAST) begin
                  state  <= DONE;
                  done   <= 1'b1;
                  rdAddr <= '0;
               end else
                  rdAddr <= rdAddr + 1'b1;
            end
            HOLD:
               // the held index, not rdAddr, decides where the walk resumes
               if (outReady) begin
                  outValid <= 1'b0;
                  if (outIndex == LAST) begin
                     state  <= DONE;
                     done   <= 1'b1;
                     rdAddr <= '0;
                  end else begin
                     rdAddr <= outIndex + 1'b1;
                     state  <= READ;
                  end
               end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
endmodule
